stage3_accumulator: RTL and testbench
=====================================

# stage3_accumulator

Final stage of the pipelined adder tree, directly downstream of the stage-2 pair adder. It consumes the two registered partial sums each cycle, forms their full-width total in a stage-3 register, and accumulates BLOCK_LEN consecutive valid totals into one block sum. Block sums are queued in a 2-entry output FIFO with a valid/ready handshake toward the result consumer.

## Interface
- W, 8, width of each incoming partial sum
- ACC_W, 16, accumulator and block-sum width; must be ≥ W+1
- BLOCK_LEN, 4, valid totals per block; legal range 1..255
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset (sampled on clk; 0 = reset)
- p0_reg  input  W  partial sum 0 from stage 2
- p1_reg  input  W  partial sum 1 from stage 2
- in_valid  input  1  p0_reg/p1_reg carry a real sample this cycle (valid tag travelling alongside the stage-2 pipeline)
- sum_q  output  W+1  registered p0_reg+p1_reg, no truncation
- sum_valid  output  1  sum_q holds a valid total
- out_data  output  ACC_W  block sum at FIFO head
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer accepts out_data this cycle
- overflow  output  1  sticky: a block sum was dropped because the FIFO was full

## Operation
- Stage-3 register: each edge, sum_q ← zero-extended p0_reg + p1_reg (W+1 bits, carry kept); sum_valid ← in_valid. sum_q updates even when in_valid=0; only sum_valid qualifies it.
- Accumulator acc (ACC_W) and counter cnt (0..BLOCK_LEN-1) advance only on sum_valid=1.
- sum_valid=1 and cnt<BLOCK_LEN-1: acc ← acc+sum_q, cnt ← cnt+1.
- sum_valid=1 and cnt=BLOCK_LEN-1: push acc+sum_q into FIFO; acc ← 0, cnt ← 0. BLOCK_LEN=1 pushes every total.
- sum_valid=0: acc, cnt hold; gaps in in_valid never break a block.
- Arithmetic: acc+sum_q modulo 2^ACC_W (see Configuration).
- FIFO: depth 2, head on out_data; pop when out_valid & out_ready.
- Push and pop same edge: both happen; legal when full (occupancy unchanged, order preserved).
- Push when full with no pop: new block sum discarded, FIFO unchanged, overflow ← 1; block counter still restarts.
- Pop when empty: no effect.
- overflow clears only on reset.
- out_data is don't-care while out_valid=0; bench must not check it.

## Timing
- Reset (rst=0 at an edge): sum_q=0, sum_valid=0, acc=0, cnt=0, FIFO emptied, out_valid=0, out_data=0, overflow=0. Reset wins over every other event, including mid-block (partial acc lost) and simultaneous push/pop.
- Sample latency: p0_reg/p1_reg/in_valid sampled at edge E0 → sum_q/sum_valid visible after E0.
- Block latency: last total's in_valid sampled at E0 → pushed at E1 → out_valid=1 after E1 (2 cycles).
- out_valid combinational from FIFO state only; no combinational path from out_ready to out_valid or out_data.
- Throughput: one sample per cycle sustained; one block per BLOCK_LEN valid cycles, no bubbles.

## Configuration
- STAGE3_SAT_EN defined: accumulate and final push saturate at 2^ACC_W-1 (unsigned); saturated value is pushed, acc then restarts at 0.
- STAGE3_SAT_EN undefined: accumulation wraps modulo 2^ACC_W.
- Defaults (W=8, ACC_W=16, BLOCK_LEN≤128) cannot overflow; saturation only matters for narrower ACC_W.

## Test plan
- Reset hold: rst=0 for 3 cycles with in_valid=1, p0=p1=0xFF → sum_valid=0, out_valid=0, overflow=0, sum_q=0 throughout.
- Single total: p0=0xFF, p1=0xFF, in_valid one cycle → next cycle sum_q=0x1FE (510), sum_valid=1.
- Block of 4 with gaps: totals 10,20,30,40 with idle cycles between, out_ready=1 → one out_valid pulse with out_data=100, 2 cycles after last input.
- Backpressure/overflow: out_ready=0, three blocks of 4×(p0=1,p1=1) → FIFO holds 8,8; third dropped, overflow=1; then out_ready=1 → two pops of 8, out_valid=0, overflow stays 1.
- Full-FIFO push+pop: FIFO full, out_ready=1 on the edge a new block (value 16) pushes → occupancy stays 2, order 8,8→8,16.
- Mid-block reset + config: 2 of 4 totals in, rst=0 one cycle → next block sums only post-reset totals; with ACC_W=9, STAGE3_SAT_EN, four totals of 510 → out_data=511; without macro → (2040 mod 512)=504.

Source files
------------

// File: rtl/stage3_accumulator.sv
// stage3_accumulator: final stage of the pipelined adder tree.
// Registers p0_reg+p1_reg at full width, accumulates BLOCK_LEN valid totals
// into one block sum and queues block sums in a 2-entry valid/ready FIFO.
// Optional macro STAGE3_SAT_EN: saturate the block accumulation at
// 2^ACC_W-1 instead of wrapping modulo 2^ACC_W.
module stage3_accumulator #(
  parameter int W         = 8,
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     p0_reg,
  input  logic [W-1:0]     p1_reg,
  input  logic             in_valid,
  output logic [W:0]       sum_q,
  output logic             sum_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  // BLOCK_LEN tops out at 255, so a fixed 8-bit counter covers every legal value
  // (and avoids a zero-width counter when BLOCK_LEN=1).
  localparam int              CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

  logic [ACC_W-1:0]      acc;
  logic [CNT_W-1:0]      cnt;
  logic [ACC_W:0]        sum_full;
  logic [ACC_W-1:0]      acc_nxt;
  logic                  blk_done;

  logic [1:0][ACC_W-1:0] mem;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic                  full;
  logic                  pop;
  logic                  wr_en;

  // Stage-3 register: total always updates, valid tag qualifies it
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q     <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_q     <= {1'b0, p0_reg} + {1'b0, p1_reg};
      sum_valid <= in_valid;
    end
  end

  // One extra bit on the add exposes the carry for saturation
  assign sum_full = {1'b0, acc} + {{(ACC_W - W){1'b0}}, sum_q};

  // Next accumulator value: saturate or wrap depending on build
  always_comb begin
    acc_nxt = sum_full[ACC_W-1:0];
`ifdef STAGE3_SAT_EN
    if (sum_full[ACC_W]) acc_nxt = '1;
`endif
  end

  assign blk_done = sum_valid && (cnt == LAST);

  // Block accumulator: advances only on valid totals, restarts after each block
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (sum_valid) begin
      if (blk_done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A full FIFO still accepts a push if the head leaves on the same edge
  assign full      = (occ == 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign wr_en     = blk_done && (!full || pop);

  // Output FIFO state plus sticky overflow on a dropped block sum
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem      <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= acc_nxt;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({wr_en, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (blk_done && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stage3_accumulator.sv
// Directed bench for stage3_accumulator: table of stage-3 sum vectors plus
// hand-written block, backpressure, full push+pop, mid-block reset and
// narrow-accumulator (ACC_W=9) sequences.
module tb_stage3_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  p0_reg, p1_reg;
  logic        in_valid;
  logic [8:0]  sum_q, sum_q9;
  logic        sum_valid, sum_valid9;
  logic [15:0] out_data;
  logic [8:0]  out_data9;
  logic        out_valid, out_valid9;
  logic        out_ready;
  logic        overflow, overflow9;

  int n_pass = 0;
  int n_tot  = 0;

  stage3_accumulator #(.W(8), .ACC_W(16), .BLOCK_LEN(4)) dut (
    .clk(clk), .rst(rst), .p0_reg(p0_reg), .p1_reg(p1_reg), .in_valid(in_valid),
    .sum_q(sum_q), .sum_valid(sum_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow));

  stage3_accumulator #(.W(8), .ACC_W(9), .BLOCK_LEN(4)) dut9 (
    .clk(clk), .rst(rst), .p0_reg(p0_reg), .p1_reg(p1_reg), .in_valid(in_valid),
    .sum_q(sum_q9), .sum_valid(sum_valid9), .out_data(out_data9), .out_valid(out_valid9),
    .out_ready(out_ready), .overflow(overflow9));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] p0;
    logic [7:0] p1;
    logic       vld;
    logic [8:0] exp_sum;
    logic       exp_vld;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Advance one edge; outputs are read 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v);
    p0_reg = a; p1_reg = b; in_valid = v;
  endtask

  task automatic do_reset();
    rst = 1'b0; drive(8'd0, 8'd0, 1'b0);
    step();
    rst = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'hFF, 8'hFF, 1'b1, 9'h1FE, 1'b1};
    vecs[1] = '{8'h00, 8'h00, 1'b1, 9'h000, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b1, 9'h100, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 9'h046, 1'b0};
    vecs[4] = '{8'hFF, 8'h01, 1'b1, 9'h100, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b1, 9'h080, 1'b1};

    out_ready = 1'b0;

    // Reset hold with live-looking inputs
    rst = 1'b0;
    drive(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_sum_valid", sum_valid, 0);
      chk("rst_sum_q", sum_q, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_overflow", overflow, 0);
    end
    chk("rst_out_data", out_data, 0);
    rst = 1'b1;
    drive(8'd0, 8'd0, 1'b0);
    step();

    // Stage-3 register vectors
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].p0, vecs[i].p1, vecs[i].vld);
      step();
      chk($sformatf("vec%0d_sum_q", i), sum_q, vecs[i].exp_sum);
      chk($sformatf("vec%0d_sum_valid", i), sum_valid, vecs[i].exp_vld);
    end

    // Block of 4 with idle gaps: 10+20+30+40
    do_reset();
    out_ready = 1'b1;
    drive(8'd5, 8'd5, 1'b1);   step();
    drive(8'd0, 8'd0, 1'b0);   step();
    drive(8'd10, 8'd10, 1'b1); step();
    drive(8'd0, 8'd0, 1'b0);   step();
    drive(8'd15, 8'd15, 1'b1); step();
    drive(8'd0, 8'd0, 1'b0);   step();
    drive(8'd20, 8'd20, 1'b1); step();
    drive(8'd0, 8'd0, 1'b0);
    chk("blk_last_sum_valid", sum_valid, 1);
    chk("blk_not_yet_valid", out_valid, 0);
    step();
    chk("blk_out_valid", out_valid, 1);
    chk("blk_out_data", out_data, 100);
    step();
    chk("blk_pulse_end", out_valid, 0);

    // Backpressure: three blocks of 8, third dropped
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(8'd1, 8'd1, 1'b1); step();
    end
    drive(8'd0, 8'd0, 1'b0);
    step();
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_data, 8);
    chk("bp_overflow", overflow, 1);
    out_ready = 1'b1;
    step();
    chk("bp_pop1_valid", out_valid, 1);
    chk("bp_pop1_data", out_data, 8);
    step();
    chk("bp_empty", out_valid, 0);
    chk("bp_overflow_sticky", overflow, 1);
    out_ready = 1'b0;

    // Full FIFO: push of 16 and pop on the same edge
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(8'd1, 8'd1, 1'b1); step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(8'd2, 8'd2, 1'b1); step();
    end
    drive(8'd0, 8'd0, 1'b0);
    chk("pp_full_head", out_data, 8);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp_no_overflow", overflow, 0);
    chk("pp_valid", out_valid, 1);
    chk("pp_head", out_data, 8);
    step();
    chk("pp_still_full", out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("pp_second", out_data, 16);
    chk("pp_second_valid", out_valid, 1);
    step();
    chk("pp_drained", out_valid, 0);
    out_ready = 1'b0;

    // Mid-block reset drops partial accumulation
    do_reset();
    out_ready = 1'b1;
    drive(8'd50, 8'd50, 1'b1); step();
    drive(8'd50, 8'd50, 1'b1); step();
    rst = 1'b0; drive(8'd0, 8'd0, 1'b0);
    step();
    rst = 1'b1;
    chk("mr_sum_valid", sum_valid, 0);
    for (int i = 0; i < 4; i++) begin
      drive(8'd1, 8'd1, 1'b1); step();
    end
    drive(8'd0, 8'd0, 1'b0);
    step();
    chk("mr_out_valid", out_valid, 1);
    chk("mr_out_data", out_data, 8);
    step();

    // Narrow accumulator: four totals of 510 into ACC_W=9
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(8'hFF, 8'hFF, 1'b1); step();
    end
    drive(8'd0, 8'd0, 1'b0);
    step();
    chk("n9_out_valid", out_valid9, 1);
`ifdef STAGE3_SAT_EN
    chk("n9_out_data_sat", out_data9, 511);
`else
    chk("n9_out_data_wrap", out_data9, 504);
`endif
    chk("n9_wide_out_data", out_data, 2040);
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
